// File: rtl/tpu_pkg.sv
// Shared parameters, opcodes and FSM state encoding for the tpu sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tpu_pkg;

    localparam int N_DEF  = 2;
    localparam int DW_DEF = 8;
    localparam int AW_DEF = 16;

    localparam logic [1:0] OP_LOAD_W = 2'd0;
    localparam logic [1:0] OP_LOAD_A = 2'd1;
    localparam logic [1:0] OP_RUN    = 2'd2;
    localparam logic [1:0] OP_CLR    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_A,
        COMPUTE,
        READOUT
    } state_t;

endpackage

// File: rtl/tpu_sequencer_if.sv
// Command stream, result stream and systolic-array control bundle.
// Latency: none (wires only).
// Backpressure: cmd_ready stalls the command source, out_ready stalls the sequencer.
interface tpu_sequencer_if
    import tpu_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) ();
    localparam int IW = (N * N > 1) ? $clog2(N * N) : 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_data;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          arr_clear;
    logic          arr_w_we;
    logic          arr_a_we;
    logic [IW-1:0] arr_idx;
    logic [DW-1:0] arr_wdata;
    logic          arr_step;
    logic [AW-1:0] arr_res;

    // Environment side: command source, result sink and the array itself.
    modport master (
        output cmd_valid, cmd_data, out_ready, arr_res,
        input  cmd_ready, out_valid, out_data,
               arr_clear, arr_w_we, arr_a_we, arr_idx, arr_wdata, arr_step
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_data, out_ready, arr_res,
        output cmd_ready, out_valid, out_data,
               arr_clear, arr_w_we, arr_a_we, arr_idx, arr_wdata, arr_step
    );
endinterface

// File: rtl/tpu_result_serializer.sv
// Splits one AW-bit result into AW/8 bytes, LS byte first, with a valid/ready hold register.
// Latency: first byte presented combinationally from res_in in the cycle vld_in rises.
// Backpressure: out_data/out_valid held stable while out_ready is low; flush drops a partial word.
module tpu_result_serializer
    import tpu_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          vld_in,
    input  logic [AW-1:0] res_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          word_done
);
    localparam int NB = AW / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    logic [AW-1:0] hold;
    logic [BW-1:0] bsel;
    logic          full;
    logic [7:0]    cur_byte;
    logic          xfer;

    // Byte select: the live result for the first byte, the held copy afterwards.
    always_comb begin
        cur_byte = res_in[7:0];
        if (full) begin
            cur_byte = hold[7:0];
            for (int b = 0; b < NB; b++) begin
                if (bsel == BW'(b)) cur_byte = hold[8*b +: 8];
            end
        end
    end

    assign out_valid = vld_in;
    assign out_data  = vld_in ? cur_byte : 8'd0;
    assign xfer      = out_valid & out_ready;
    assign word_done = xfer & (bsel == BW'(NB - 1));

    // Capture the result on first presentation, then walk the byte pointer on each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
            bsel <= '0;
            full <= 1'b0;
        end else if (flush) begin
            bsel <= '0;
            full <= 1'b0;
        end else if (vld_in) begin
            if (!full) hold <= res_in;
            if (word_done) begin
                bsel <= '0;
                full <= 1'b0;
            end else begin
                full <= 1'b1;
                if (xfer) bsel <= bsel + BW'(1);
            end
        end
    end
endmodule

// File: rtl/tpu_sequencer.sv
// Loads weight/activation tiles, steps the systolic array, then streams results out bytewise.
// Latency: load strobes same cycle as byte accept; 1 clear + 3N-1 step cycles; readout from next cycle.
// Backpressure: cmd_ready low outside IDLE/LOAD, or when ena=0/abort; readout stalls on out_ready.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            abort,
    tpu_sequencer_if.slave  bus,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int IW   = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int CW   = $clog2(3 * N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);
    localparam logic [CW-1:0] LAST_CYC = CW'(3 * N - 1);

    state_t        state, state_nxt;
    logic [IW-1:0] cnt;
    logic [CW-1:0] cyc;
    logic          w_ok, a_ok;
    logic          live;
    logic          cmd_xfer;
    logic          ser_vld;
    logic          word_done;
    logic [1:0]    op;

    assign live     = ena & ~abort;
    assign cmd_xfer = bus.cmd_ready & bus.cmd_valid;
    assign op       = bus.cmd_data[1:0];
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and array/command strobes; abort wins over any transfer.
    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.arr_w_we  = 1'b0;
        bus.arr_a_we  = 1'b0;
        bus.arr_clear = 1'b0;
        bus.arr_step  = 1'b0;
        ser_vld       = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = live;
                if (cmd_xfer) begin
                    case (op)
                        OP_LOAD_W: state_nxt = LOAD_W;
                        OP_LOAD_A: state_nxt = LOAD_A;
                        OP_RUN:    if (w_ok && a_ok) state_nxt = COMPUTE;
                        default:   state_nxt = IDLE;
                    endcase
                end
            end
            LOAD_W: begin
                bus.cmd_ready = live;
                bus.arr_w_we  = cmd_xfer;
                if (cmd_xfer && cnt == LAST_IDX) state_nxt = IDLE;
            end
            LOAD_A: begin
                bus.cmd_ready = live;
                bus.arr_a_we  = cmd_xfer;
                if (cmd_xfer && cnt == LAST_IDX) state_nxt = IDLE;
            end
            COMPUTE: begin
                if (live) begin
                    if (cyc == '0) bus.arr_clear = 1'b1;
                    else           bus.arr_step  = 1'b1;
                    if (cyc == LAST_CYC) state_nxt = READOUT;
                end
            end
            READOUT: begin
                ser_vld = live;
                if (word_done && cnt == LAST_IDX) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    assign bus.arr_idx   = cnt;
    assign bus.arr_wdata = (bus.arr_w_we | bus.arr_a_we) ? bus.cmd_data[DW-1:0] : '0;

    // Byte/result counter, compute cycle counter, loaded flags, sticky error and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            cyc  <= '0;
            w_ok <= 1'b0;
            a_ok <= 1'b0;
            err  <= 1'b0;
            done <= 1'b0;
        end else if (abort) begin
            cnt  <= '0;
            cyc  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_xfer) begin
                        cnt <= '0;
                        cyc <= '0;
                        case (op)
                            OP_LOAD_W: w_ok <= 1'b0;
                            OP_LOAD_A: a_ok <= 1'b0;
                            OP_RUN:    if (!(w_ok && a_ok)) err <= 1'b1;
                            default: begin
                                err  <= 1'b0;
                                w_ok <= 1'b0;
                                a_ok <= 1'b0;
                            end
                        endcase
                    end
                end
                LOAD_W, LOAD_A: begin
                    if (cmd_xfer) begin
                        if (cnt == LAST_IDX) begin
                            cnt <= '0;
                            if (state == LOAD_W) w_ok <= 1'b1;
                            else                 a_ok <= 1'b1;
                        end else begin
                            cnt <= cnt + IW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (live) cyc <= (cyc == LAST_CYC) ? '0 : cyc + CW'(1);
                end
                READOUT: begin
                    if (word_done) begin
                        if (cnt == LAST_IDX) begin
                            cnt  <= '0;
                            done <= 1'b1;
                        end else begin
                            cnt <= cnt + IW'(1);
                        end
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    tpu_result_serializer #(.AW(AW)) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .vld_in    (ser_vld),
        .res_in    (bus.arr_res),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .word_done (word_done)
    );
endmodule
